// File: rtl/riscv_if_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface riscv_if_if #(
  parameter int XLEN = 32
) ();
  logic            o_if_imem_req;
  logic [XLEN-1:0] o_if_imem_addr;
  logic            i_if_imem_ready;
  logic [XLEN-1:0] i_if_imem_rdata;

  modport master (
    output o_if_imem_req, o_if_imem_addr,
    input  i_if_imem_ready, i_if_imem_rdata
  );

  modport slave (
    input  o_if_imem_req, o_if_imem_addr,
    output i_if_imem_ready, i_if_imem_rdata
  );
endinterface

// File: rtl/riscv_if.sv
// RV32 instruction-fetch stage: PC, imem handshake, one-entry skid buffer and IF/ID register.
// Optional performance counters are compiled in when RISCV_IF_PERF_EN is defined.
module riscv_if #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_if_stall,
  input  logic            i_if_flush,
  input  logic            i_if_pc_sel,
  input  logic [XLEN-1:0] i_if_pc_target,
  riscv_if_if.master      imem,
  output logic [XLEN-1:0] o_id_instr,
  output logic [XLEN-1:0] o_id_pc,
  output logic [XLEN-1:0] o_id_pc_plus4,
  output logic            o_id_valid,
  output logic            o_if_busy
`ifdef RISCV_IF_PERF_EN
  ,
  output logic [31:0]     o_if_perf_fetch_cnt,
  output logic [31:0]     o_if_perf_stall_cnt
`endif
);

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_KILL} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;

  logic req;
  logic busy;
  logic ready;
  logic redir_now;
  logic redir_pend;
  logic kill_done;
  logic capture;
  logic skid_load;
  logic skid_move;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] p);
    return p & ~XLEN'(3);
  endfunction

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] p);
    return p + XLEN'(4);
  endfunction

  assign ready = imem.i_if_imem_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (redir_pend)         state_nxt = S_KILL;
        else if (req && !ready) state_nxt = S_WAIT;
        else                    state_nxt = S_FETCH;
      end
      S_WAIT: begin
        if (redir_pend)     state_nxt = S_KILL;
        else if (redir_now) state_nxt = S_FETCH;
        else if (ready)     state_nxt = i_if_stall ? S_HOLD : S_FETCH;
        else                state_nxt = S_WAIT;
      end
      S_HOLD: begin
        if (i_if_pc_sel || !i_if_stall) state_nxt = S_FETCH;
      end
      S_KILL: begin
        if (ready) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A redirect lands immediately unless a request is in flight without its
  // response; then the target is parked until the stale response drains.
  always_comb begin
    req  = 1'b0;
    busy = 1'b0;
    unique case (state)
      S_FETCH:        req = !i_if_stall;
      S_WAIT, S_KILL: begin
        req  = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
    redir_now  = i_if_pc_sel && (!req || ready);
    redir_pend = i_if_pc_sel && req && !ready;
    capture    = (state == S_FETCH || state == S_WAIT) && req && ready &&
                 !i_if_pc_sel && !i_if_stall;
    skid_load  = (state == S_WAIT) && ready && i_if_stall && !i_if_pc_sel;
    skid_move  = (state == S_HOLD) && !i_if_stall && !i_if_pc_sel;
    kill_done  = (state == S_KILL) && ready && !i_if_pc_sel;
  end

  assign imem.o_if_imem_req  = i_rstn && req;
  assign imem.o_if_imem_addr = pc;
  assign o_if_busy           = i_rstn && busy;

  // PC / IF-ID stage boundary
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pc            <= RESET_PC;
      pend_pc       <= '0;
      o_id_instr    <= NOP_INSTR;
      o_id_pc       <= '0;
      o_id_pc_plus4 <= '0;
      o_id_valid    <= 1'b0;
    end else begin
      if (redir_now)                   pc <= pc_align(i_if_pc_target);
      else if (kill_done)              pc <= pend_pc;
      else if (capture || skid_load)   pc <= pc_inc(pc);

      if (redir_pend) pend_pc <= pc_align(i_if_pc_target);

      if (i_if_flush) begin
        o_id_instr <= NOP_INSTR;
        o_id_valid <= 1'b0;
      end else if (!i_if_stall) begin
        if (capture) begin
          o_id_instr    <= imem.i_if_imem_rdata;
          o_id_pc       <= pc;
          o_id_pc_plus4 <= pc_inc(pc);
          o_id_valid    <= 1'b1;
        end else if (skid_move) begin
          o_id_instr    <= skid_instr;
          o_id_pc       <= skid_pc;
          o_id_pc_plus4 <= pc_inc(skid_pc);
          o_id_valid    <= 1'b1;
        end else begin
          o_id_instr <= NOP_INSTR;
          o_id_valid <= 1'b0;
        end
      end
    end
  end

  // Skid entry is meaningful only in HOLD, so its payload carries no reset
  always_ff @(posedge i_clk) begin
    if (skid_load) begin
      skid_instr <= imem.i_if_imem_rdata;
      skid_pc    <= pc;
    end
  end

`ifdef RISCV_IF_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (!i_if_flush && !i_if_stall && (capture || skid_move))
        fetch_cnt <= fetch_cnt + 32'd1;
      if (busy)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign o_if_perf_fetch_cnt = fetch_cnt;
  assign o_if_perf_stall_cnt = stall_cnt;
`endif

endmodule
